// File: rtl/res_pkg.sv
// ----------------------------------------------------------------------------
// res_pkg
// Shared definitions for the reservoir state-update datapath: sequencer FSM
// state encoding and default geometry of the ROM, PE array and feedback path.
// ----------------------------------------------------------------------------
package res_pkg;

    // Default sequencer geometry
    localparam int RES_ADDR_W  = 6;   // input-ROM address width
    localparam int RES_ROM_LAT = 2;   // cycles from rom_addr change to valid data
    localparam int RES_PE_LAT  = 4;   // PE pipeline depth (cycles of pe_ce)
    localparam int RES_CNT_W   = 3;   // wait counter width, holds max latency - 1

    // Datapath geometry shared with the PE array and feedback registers
    localparam int RES_DATA_W  = 16;  // PE data width
    localparam int RES_NODES   = 8;   // reservoir node count

    // Sequencer states, one per phase of the per-sample schedule
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FETCH,
        ST_COMPUTE,
        ST_CAPTURE,
        ST_OUTPUT,
        ST_FINISH
    } res_seq_state_t;

endpackage : res_pkg

// File: rtl/res_wait_ctr.sv
// ----------------------------------------------------------------------------
// res_wait_ctr
// Loadable down-counter with a terminal-count flag. Loading N makes tc rise
// after N further cycles, so a phase that must last L cycles loads L-1 on entry
// and leaves on the cycle tc is high. The counter parks at zero.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous reset, active-high
//   load      in   load load_val on the next edge (has priority over counting)
//   load_val  in   value to load
//   tc        out  counter is zero (terminal count)
// ----------------------------------------------------------------------------
module res_wait_ctr #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop updates from pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule : res_wait_ctr

// File: rtl/res_seq_ctrl.sv
// ----------------------------------------------------------------------------
// res_seq_ctrl
// Per-sample sequencer for the reservoir state update:
//   CLEAR (once per run) -> FETCH (ROM_LAT) -> COMPUTE (PE_LAT) -> CAPTURE
//   -> OUTPUT (valid/ready) -> next FETCH, or FINISH -> IDLE.
// Runs are single-pass or looping over addresses 0..last_addr.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high; aborts a run without done
//   start      in   start request, honoured only in IDLE
//   stop       in   stop request, sticky until the run ends
//   loop       in   sampled at start: wrap to 0 after last_addr
//   last_addr  in   final sample address of a pass, sampled at start
//   rom_addr   out  input-ROM address of the sample in flight
//   pe_ce      out  PE clock enable, high for PE_LAT cycles per sample
//   fb_clr     out  one-cycle clear of feedback state at run start
//   fb_load    out  one-cycle load of PE results into feedback/output regs
//   out_valid  out  new state available
//   out_ready  in   downstream accepts state
//   out_addr   out  sample address of the presented state
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse when a run ends normally
// ----------------------------------------------------------------------------
module res_seq_ctrl
    import res_pkg::*;
#(
    parameter int ADDR_W  = RES_ADDR_W,
    parameter int ROM_LAT = RES_ROM_LAT,
    parameter int PE_LAT  = RES_PE_LAT,
    parameter int CNT_W   = RES_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              pe_ce,
    output logic              fb_clr,
    output logic              fb_load,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
);

    res_seq_state_t    state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] last_q;
    logic              loop_q;
    logic              stop_req;

    logic              ctr_load;
    logic [CNT_W-1:0]  ctr_load_val;
    logic              ctr_tc;

    logic              xfer;
    logic              run_end;

    assign xfer    = (state == ST_OUTPUT) && out_ready;
    assign run_end = stop_req || stop || ((addr == last_q) && !loop_q);

    // The counter is loaded on entry to each timed phase: ROM wait when FETCH
    // is entered (from CLEAR or after a transfer), PE wait when COMPUTE is
    // entered. A load on a final transfer is harmless; FINISH ignores it.
    assign ctr_load     = (state == ST_CLEAR) || xfer || ((state == ST_FETCH) && ctr_tc);
    assign ctr_load_val = (state == ST_FETCH) ? CNT_W'(PE_LAT - 1) : CNT_W'(ROM_LAT - 1);

    res_wait_ctr #(
        .CNT_W (CNT_W)
    ) u_wait_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load),
        .load_val (ctr_load_val),
        .tc       (ctr_tc)
    );

    // The address register is the ROM address: it changes only on start or a
    // transfer, so it is stable from FETCH through OUTPUT and holds in IDLE.
    assign rom_addr = addr;

    // Outputs are registered and set on the edge that enters their state, so
    // each one is high exactly while the FSM is in the corresponding state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr      <= '0;
            last_q    <= '0;
            loop_q    <= 1'b0;
            stop_req  <= 1'b0;
            pe_ce     <= 1'b0;
            fb_clr    <= 1'b0;
            fb_load   <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Single-cycle pulses default low; the entering transition raises them.
            fb_clr  <= 1'b0;
            fb_load <= 1'b0;
            done    <= 1'b0;

            // Stop is remembered in any busy state; FINISH below overrides it.
            if (stop && (state != ST_IDLE)) begin
                stop_req <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        loop_q   <= loop;
                        last_q   <= last_addr;
                        addr     <= '0;
                        stop_req <= 1'b0;
                        fb_clr   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_CLEAR;
                    end
                end

                ST_CLEAR: begin
                    state <= ST_FETCH;
                end

                ST_FETCH: begin
                    if (ctr_tc) begin
                        pe_ce <= 1'b1;
                        state <= ST_COMPUTE;
                    end
                end

                ST_COMPUTE: begin
                    if (ctr_tc) begin
                        pe_ce   <= 1'b0;
                        fb_load <= 1'b1;
                        state   <= ST_CAPTURE;
                    end
                end

                ST_CAPTURE: begin
                    out_valid <= 1'b1;
                    out_addr  <= addr;
                    state     <= ST_OUTPUT;
                end

                ST_OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (run_end) begin
                            done  <= 1'b1;
                            state <= ST_FINISH;
                        end else begin
                            // Looping restarts at 0 with feedback state kept.
                            addr  <= (addr == last_q) ? '0 : addr + 1'b1;
                            state <= ST_FETCH;
                        end
                    end
                end

                ST_FINISH: begin
                    stop_req <= 1'b0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : res_seq_ctrl

// File: tb/tb_res_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_res_seq_ctrl
// Self-checking bench for res_seq_ctrl. A reference model tracks each run as
// (current sample address, cycle the sample's schedule started, finish cycle)
// and derives every expected output from the cycle offset into the sample:
//   offset 1..ROM_LAT            ROM wait
//   offset ROM_LAT+1..+PE_LAT    pe_ce
//   offset ROM_LAT+PE_LAT+1      fb_load
//   offset >= ROM_LAT+PE_LAT+2   out_valid until a transfer
// Directed scenarios come first, then randomized inputs.
// ----------------------------------------------------------------------------
module tb_res_seq_ctrl;

    localparam int AW   = 6;
    localparam int RLAT = 2;
    localparam int PLAT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic          loop;
    logic [AW-1:0] last_addr;
    logic [AW-1:0] rom_addr;
    logic          pe_ce;
    logic          fb_clr;
    logic          fb_load;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic          busy;
    logic          done;

    res_seq_ctrl #(
        .ADDR_W  (AW),
        .ROM_LAT (RLAT),
        .PE_LAT  (PLAT),
        .CNT_W   (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .loop      (loop),
        .last_addr (last_addr),
        .rom_addr  (rom_addr),
        .pe_ce     (pe_ce),
        .fb_clr    (fb_clr),
        .fb_load   (fb_load),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model
    bit m_run      = 0;   // a run is in progress (CLEAR through FINISH)
    bit m_loop     = 0;
    int m_last     = 0;
    int m_cur      = 0;   // sample address in flight
    int m_anchor   = 0;   // cycle before this sample's first ROM-wait cycle
    int m_clr      = -1;  // cycle fb_clr is expected
    int m_fin      = -1;  // cycle done is expected
    bit m_stop_req = 0;
    bit m_rstd     = 0;   // the latest edge was a reset

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, act, exp);
        end
    endtask

    function automatic bit exp_valid(input int n);
        return m_run && (m_fin < 0) && ((n - m_anchor) >= RLAT + PLAT + 2);
    endfunction

    // Advance the model across one rising edge, using the inputs the DUT sees.
    task automatic model_step();
        bit prev_valid;
        prev_valid = exp_valid(cyc);
        cyc++;
        m_rstd = 0;
        if (rst) begin
            m_run      = 0;
            m_cur      = 0;
            m_clr      = -1;
            m_fin      = -1;
            m_stop_req = 0;
            m_rstd     = 1;
        end else if (!m_run) begin
            if (start) begin
                m_run      = 1;
                m_loop     = loop;
                m_last     = int'(last_addr);
                m_cur      = 0;
                m_anchor   = cyc;
                m_clr      = cyc;
                m_fin      = -1;
                m_stop_req = 0;
            end
        end else if (cyc - 1 == m_fin) begin
            m_run = 0;
        end else begin
            if (stop) m_stop_req = 1;
            if (prev_valid && out_ready) begin
                if (m_stop_req || (m_cur == m_last && !m_loop)) begin
                    m_fin = cyc;
                end else begin
                    m_cur    = (m_cur == m_last) ? 0 : (m_cur + 1) % (1 << AW);
                    m_anchor = cyc - 1;
                end
            end
        end
    endtask

    task automatic model_check();
        int d;
        bit act;
        d   = cyc - m_anchor;
        act = m_run && (m_fin < 0);
        check("pe_ce",     32'(pe_ce),     32'(act && d >= RLAT + 1 && d <= RLAT + PLAT));
        check("fb_load",   32'(fb_load),   32'(act && d == RLAT + PLAT + 1));
        check("out_valid", 32'(out_valid), 32'(exp_valid(cyc)));
        check("fb_clr",    32'(fb_clr),    32'(m_run && cyc == m_clr));
        check("done",      32'(done),      32'(cyc == m_fin));
        check("busy",      32'(busy),      32'(m_run));
        check("rom_addr",  32'(rom_addr),  32'(m_cur));
        if (exp_valid(cyc)) check("out_addr", 32'(out_addr), 32'(m_cur));
        else if (m_rstd)    check("out_addr_rst", 32'(out_addr), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        model_check();
    endtask

    task automatic begin_run(input logic [AW-1:0] last, input logic lp);
        start     = 1'b1;
        last_addr = last;
        loop      = lp;
        tick();
        start     = 1'b0;
        last_addr = $urandom_range(0, 63);  // must not matter after start
        loop      = $urandom_range(0, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
        last_addr = '0; out_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;

        // Basic 3-sample run, ready tied high
        begin_run(6'd2, 1'b0);
        repeat (30) tick();

        // Backpressure in OUTPUT of sample 1
        begin_run(6'd3, 1'b0);
        repeat (16) tick();
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
        repeat (30) tick();

        // Full-range looping run wraps 63 -> 0, then stop
        begin_run(6'd63, 1'b1);
        repeat (64 * 8 + 20) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (20) tick();

        // Stop during COMPUTE of sample 5
        begin_run(6'd10, 1'b0);
        repeat (5 * 8 + 4) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (20) tick();

        // Start pulsed while busy is ignored
        begin_run(6'd5, 1'b0);
        repeat (3 * 8 + 2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();

        // Reset while stalled in OUTPUT
        begin_run(6'd5, 1'b0);
        repeat (7) tick();
        out_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();

        // Start and stop together in IDLE: start wins; single-sample pass
        stop = 1'b1;
        begin_run(6'd0, 1'b0);
        stop = 1'b0;
        repeat (15) tick();

        // Randomized phase
        for (int i = 0; i < 6000; i++) begin
            rst       = ($urandom_range(0, 399) == 0);
            start     = ($urandom_range(0, 7) == 0);
            stop      = ($urandom_range(0, 39) == 0);
            loop      = ($urandom_range(0, 3) == 0);
            last_addr = ($urandom_range(0, 3) == 0) ? 6'd63 : AW'($urandom_range(0, 6));
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_res_seq_ctrl
